// File: rtl/fxp_pkg.sv
// Shared fixed-point constants for the Horner evaluation datapath.
// Rounding-mode codes and the Q16 default geometry.
package fxp_pkg;

    localparam int unsigned RND_TRUNC = 0;
    localparam int unsigned RND_HAFZ  = 1;
    localparam int unsigned RND_EVEN  = 2;

    localparam int unsigned Q16_W    = 32;
    localparam int unsigned Q16_FRAC = 16;

endpackage

// File: rtl/fxp_round_sat.sv
// Rescales a 2W-bit fixed-point product down to W bits with selectable rounding,
// then either clamps or wraps, reporting overflow in both cases.
module fxp_round_sat
    import fxp_pkg::*;
#(
    parameter int unsigned W        = Q16_W,
    parameter int unsigned FRAC     = Q16_FRAC,
    parameter int unsigned RND_MODE = RND_HAFZ,
    parameter int unsigned SAT      = 1
) (
    input  logic [2*W-1:0] i_prod,
    output logic [W-1:0]   o_y,
    output logic           o_ovf
);

    localparam int unsigned   XW      = 2 * W + 1;
    localparam logic [XW-1:0] HALF    = XW'(1) << (FRAC - 1);
    localparam logic [XW-1:0] HALF_M1 = HALF - XW'(1);
    localparam logic [W-1:0]  Y_MAX   = {1'b0, {(W - 1){1'b1}}};
    localparam logic [W-1:0]  Y_MIN   = {1'b1, {(W - 1){1'b0}}};

    logic [XW-1:0] w_ext;
    logic [XW-1:0] w_bias;
    logic [XW-1:0] w_sum;
    logic [XW-1:0] w_r;
    logic [W+1:0]  w_hi;

    always_comb begin
        // One extra bit of headroom so the rounding add can never overflow.
        w_ext  = {i_prod[2*W-1], i_prod};
        w_bias = '0;
        case (RND_MODE)
            RND_HAFZ: w_bias = i_prod[2*W-1] ? HALF_M1 : HALF;
            RND_EVEN: w_bias = HALF_M1 + XW'(i_prod[FRAC]);
            default:  w_bias = '0;
        endcase
        w_sum = w_ext + w_bias;
        w_r   = $signed(w_sum) >>> FRAC;
        // In range only when every bit from W-1 upward matches the sign.
        w_hi  = w_r[XW-1:W-1];
        o_ovf = !((&w_hi) || !(|w_hi));
        if (o_ovf && (SAT != 0)) begin
            o_y = w_r[XW-1] ? Y_MIN : Y_MAX;
        end else begin
            o_y = w_r[W-1:0];
        end
    end

endmodule

// File: rtl/mul_qn_pipe.sv
// Two-stage pipelined signed Qm.FRAC multiplier with valid/ready flow control,
// a pass-through sideband tag and a sticky overflow flag.
module mul_qn_pipe
    import fxp_pkg::*;
#(
    parameter int unsigned W        = Q16_W,
    parameter int unsigned FRAC     = Q16_FRAC,
    parameter int unsigned RND_MODE = RND_HAFZ,
    parameter int unsigned SAT      = 1,
    parameter int unsigned TAG_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_y,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_ovf,
    output logic             ovf_sticky,
    input  logic             clr_ovf
);

    logic             w_en;
    logic [2*W-1:0]   w_a_ext;
    logic [2*W-1:0]   w_b_ext;
    logic [2*W-1:0]   w_prod;
    logic [W-1:0]     w_y;
    logic             w_ovf;

    logic             r_v1;
    logic [2*W-1:0]   r_p;
    logic [TAG_W-1:0] r_tag1;
    logic             r_v2;
    logic [W-1:0]     r_y;
    logic             r_ovf;
    logic [TAG_W-1:0] r_tag2;
    logic             r_sticky;

    // Whole pipe advances together; an empty stage stays empty while stalled.
    assign w_en     = !r_v2 || out_ready;
    assign in_ready = w_en;

    // Sign-extended operands make the low 2W bits of the product the signed result.
    assign w_a_ext = {{W{in_a[W-1]}}, in_a};
    assign w_b_ext = {{W{in_b[W-1]}}, in_b};
    assign w_prod  = w_a_ext * w_b_ext;

    fxp_round_sat #(
        .W        (W),
        .FRAC     (FRAC),
        .RND_MODE (RND_MODE),
        .SAT      (SAT)
    ) u_round_sat (
        .i_prod (r_p),
        .o_y    (w_y),
        .o_ovf  (w_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else if (w_en) begin
            r_v1 <= in_valid;
            r_v2 <= r_v1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_en) begin
            r_p    <= w_prod;
            r_tag1 <= in_tag;
            r_y    <= w_y;
            r_ovf  <= w_ovf;
            r_tag2 <= r_tag1;
        end
    end

    // A set from a transferring overflow beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky <= 1'b0;
        end else if (r_v2 && out_ready && r_ovf) begin
            r_sticky <= 1'b1;
        end else if (clr_ovf) begin
            r_sticky <= 1'b0;
        end
    end

    assign out_valid  = r_v2;
    assign out_y      = r_y;
    assign out_tag    = r_tag2;
    assign out_ovf    = r_ovf;
    assign ovf_sticky = r_sticky;

endmodule

// File: tb/tb_mul_qn_pipe.sv
// Scoreboard bench for mul_qn_pipe: four instances (truncate, half-away, half-even,
// and half-away with wrap) share one stimulus stream and are checked against a model.
module tb_mul_qn_pipe;

    localparam int NDUT = 4;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
    } item_t;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic        clr_ovf   = 1'b0;
    logic [31:0] in_a      = '0;
    logic [31:0] in_b      = '0;
    logic [3:0]  in_tag    = '0;

    logic        in_ready   [NDUT];
    logic        out_valid  [NDUT];
    logic        out_ovf    [NDUT];
    logic        ovf_sticky [NDUT];
    logic [31:0] out_y      [NDUT];
    logic [3:0]  out_tag    [NDUT];

    item_t sb[$];
    bit    mv1;
    bit    mv2;
    bit    ms [NDUT];
    bit    last_acc;
    int    n_pass   = 0;
    int    n_checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mul_qn_pipe #(
            .W        (32),
            .FRAC     (16),
            .RND_MODE ((g == 1) ? 0 : (g == 2) ? 2 : 1),
            .SAT      ((g == 3) ? 0 : 1),
            .TAG_W    (4)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid),
            .in_ready   (in_ready[g]),
            .in_a       (in_a),
            .in_b       (in_b),
            .in_tag     (in_tag),
            .out_valid  (out_valid[g]),
            .out_ready  (out_ready),
            .out_y      (out_y[g]),
            .out_tag    (out_tag[g]),
            .out_ovf    (out_ovf[g]),
            .ovf_sticky (ovf_sticky[g]),
            .clr_ovf    (clr_ovf)
        );
    end

    function automatic int mode_of(int g);
        return (g == 1) ? 0 : (g == 2) ? 2 : 1;
    endfunction

    function automatic int sat_of(int g);
        return (g == 3) ? 0 : 1;
    endfunction

    // Reference: floor quotient plus remainder-based rounding decision; returns {ovf, y}.
    function automatic logic [32:0] model(logic [31:0] a, logic [31:0] b, int mode, int sat);
        longint p;
        longint q;
        longint rem;
        longint r;
        logic        ovf;
        logic [31:0] y;
        p   = longint'($signed(a)) * longint'($signed(b));
        q   = p >>> 16;
        rem = p - (q <<< 16);
        r   = q;
        if (mode == 1) begin
            if ((p >= 0 && rem >= 32768) || (p < 0 && rem > 32768)) r = q + 1;
        end else if (mode == 2) begin
            if (rem > 32768 || (rem == 32768 && q[0])) r = q + 1;
        end
        ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        if (ovf && sat != 0) y = (r < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        else                 y = r[31:0];
        return {ovf, y};
    endfunction

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Called just after a falling edge with inputs set; checks, then advances one clock.
    task automatic cycle();
        logic        en;
        logic [32:0] e;
        bit          acc;
        bit          xfer;
        item_t       it;
        #1;
        en = !mv2 || out_ready;
        for (int g = 0; g < NDUT; g++) begin
            check_eq($sformatf("in_ready[%0d]", g), 64'(in_ready[g]), 64'(en));
            check_eq($sformatf("out_valid[%0d]", g), 64'(out_valid[g]), 64'(mv2));
            check_eq($sformatf("ovf_sticky[%0d]", g), 64'(ovf_sticky[g]), 64'(ms[g]));
        end
        if (mv2) begin
            check_eq("sb_nonempty", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                for (int g = 0; g < NDUT; g++) begin
                    e = model(sb[0].a, sb[0].b, mode_of(g), sat_of(g));
                    if (out_valid[g]) begin
                        check_eq($sformatf("out_y[%0d]", g), 64'(out_y[g]), 64'(e[31:0]));
                        check_eq($sformatf("out_tag[%0d]", g), 64'(out_tag[g]), 64'(sb[0].tag));
                        check_eq($sformatf("out_ovf[%0d]", g), 64'(out_ovf[g]), 64'(e[32]));
                    end
                end
            end
        end
        acc      = in_valid && en && !rst;
        xfer     = mv2 && out_ready && !rst;
        last_acc = acc;
        if (rst) begin
            sb.delete();
            mv1 = 1'b0;
            mv2 = 1'b0;
            for (int g = 0; g < NDUT; g++) ms[g] = 1'b0;
        end else begin
            for (int g = 0; g < NDUT; g++) begin
                e = (sb.size() > 0) ? model(sb[0].a, sb[0].b, mode_of(g), sat_of(g)) : '0;
                if (xfer && sb.size() > 0 && e[32]) ms[g] = 1'b1;
                else if (clr_ovf)                   ms[g] = 1'b0;
            end
            if (xfer && sb.size() > 0) void'(sb.pop_front());
            if (acc) begin
                it.a   = in_a;
                it.b   = in_b;
                it.tag = in_tag;
                sb.push_back(it);
            end
            if (en) begin
                mv2 = mv1;
                mv1 = in_valid;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(logic [31:0] a, logic [31:0] b, logic [3:0] tag);
        int guard;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        guard    = 0;
        do begin
            cycle();
            guard++;
        end while (!last_acc && guard < 50);
        check_eq("send_accepted", 64'(last_acc), 64'd1);
    endtask

    task automatic idle(int n);
        in_valid = 1'b0;
        repeat (n) cycle();
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0: v = $urandom();
            1: begin
                v = $urandom_range(0, 32'h3FFFF);
                v = v - 32'h20000;
            end
            2: begin
                case ($urandom_range(0, 4))
                    0:       v = 32'h7FFF_FFFF;
                    1:       v = 32'h8000_0000;
                    2:       v = 32'h0000_8000;
                    3:       v = 32'h0000_0001;
                    default: v = 32'hFFFF_FFFF;
                endcase
            end
            default: begin
                v = $urandom();
                v = v >>> $urandom_range(8, 24);
            end
        endcase
        return v;
    endfunction

    initial begin
        int n;
        int guard;
        @(negedge clk);
        rst = 1'b1;
        cycle();
        cycle();
        rst       = 1'b0;
        out_ready = 1'b1;

        // Basic product, then rounding ties, then overflow corners.
        send(32'h0001_8000, 32'h0002_0000, 4'd5);
        idle(4);
        send(32'h0000_0001, 32'h0000_8000, 4'd1);
        send(32'h0000_0003, 32'h0000_8000, 4'd2);
        send(32'hFFFF_FFFF, 32'h0000_8000, 4'd3);
        idle(4);
        send(32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'd6);
        send(32'h8000_0000, 32'h8000_0000, 4'd7);
        send(32'h8000_0000, 32'h7FFF_FFFF, 4'd8);
        idle(4);
        clr_ovf = 1'b1;
        cycle();
        clr_ovf = 1'b0;
        idle(2);

        // Backpressure: two accepts fill the pipe, third waits for ready.
        out_ready = 1'b0;
        send(32'h0001_0000, 32'h0002_0000, 4'd1);
        send(32'h0003_0000, 32'h0002_0000, 4'd2);
        in_valid = 1'b1;
        in_a     = 32'h0005_0000;
        in_b     = 32'h0002_0000;
        in_tag   = 4'd3;
        repeat (4) cycle();
        out_ready = 1'b1;
        send(32'h0005_0000, 32'h0002_0000, 4'd3);
        idle(4);

        // Reset with both stages full and the sticky flag set.
        send(32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'd9);
        send(32'h7FFF_FFFF, 32'h0002_0000, 4'd10);
        send(32'h0002_0000, 32'h0002_0000, 4'd11);
        rst      = 1'b1;
        in_valid = 1'b1;
        cycle();
        rst = 1'b0;
        idle(1);
        send(32'h0001_8000, 32'hFFFE_0000, 4'd12);
        idle(4);

        // Random valid/ready/clear traffic.
        n     = 0;
        guard = 0;
        in_valid = 1'b0;
        while (n < 1000 && guard < 30000) begin
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_a     = rand_op();
                in_b     = rand_op();
                in_tag   = 4'($urandom_range(0, 15));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            clr_ovf   = ($urandom_range(0, 7) == 0);
            cycle();
            if (last_acc) n++;
            guard++;
        end
        check_eq("random_items", 64'(n), 64'd1000);
        clr_ovf   = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        guard     = 0;
        while (sb.size() > 0 && guard < 20) begin
            cycle();
            guard++;
        end
        check_eq("drained", 64'(sb.size()), 64'd0);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mul_qn_pipe.md
Name: mul_qn_pipe

Overview:
- Pipelined, parametrised signed fixed-point multiplier. Generalises the Q16 combinational multiplier to any Qm.FRAC width.
- Adds selectable rounding (truncate, half-away-from-zero, half-even), optional saturation with overflow reporting, and valid/ready flow control.
- Carries a sideband tag (e.g. Horner coefficient index) alongside the data.
- Sits in the Horner evaluation datapath between the coefficient sequencer and the accumulator adder.

Parameters:
- W, 32, operand and result width in bits (two's complement), W ≥ 4.
- FRAC, 16, fractional bits of both operands and the result; 1 ≤ FRAC ≤ W-1.
- RND_MODE, 1, rounding mode: 0 = truncate (floor, arithmetic shift); 1 = round half away from zero (legacy Q16 behaviour); 2 = round half to even.
- SAT, 1, 1 = clamp the result to the W-bit range; 0 = wrap (keep the low W bits).
- TAG_W, 4, sideband tag width (≥ 1).

Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, synchronous active-high reset.
- in_valid, in, 1, input operands valid.
- in_ready, out, 1, block accepts input this cycle.
- in_a, in, W, signed multiplicand, Q(W-FRAC).FRAC.
- in_b, in, W, signed multiplier, Q(W-FRAC).FRAC.
- in_tag, in, TAG_W, sideband, passed through unchanged.
- out_valid, out, 1, result valid.
- out_ready, in, 1, downstream accepts the result.
- out_y, out, W, signed result, Q(W-FRAC).FRAC.
- out_tag, out, TAG_W, tag aligned with out_y.
- out_ovf, out, 1, this result overflowed W bits (saturated or wrapped).
- ovf_sticky, out, 1, set on any transferred result with out_ovf = 1.
- clr_ovf, in, 1, clears ovf_sticky.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: stage valids v1 = v2 = 0, out_valid = 0, ovf_sticky = 0. out_y, out_tag and out_ovf are don't-care while out_valid = 0; the bench must not check them.
- Pipeline structure:
  - Two register stages with a global enable: en = !v2 || out_ready.
  - in_ready = en, driven combinationally from v2 and out_ready.
  - When en = 1:
    - Stage 1 takes v1 <= in_valid, p <= in_a*in_b (full 2W-bit signed product), and the tag.
    - Stage 2 takes v2 <= v1, the rounded/saturated result, the ovf bit and the tag.
  - When en = 0, all registers hold.
- Timing: latency is exactly 2 clocks from the accept edge to out_valid. Throughput is 1 per clock while out_ready = 1.
- Bubbles are not collapsed: a stalled pipeline keeps any empty stage empty.
- Data is never dropped or duplicated, and results leave in acceptance order.
- A transfer occurs on any edge where valid and ready are both 1. out_* are stable while out_valid = 1 and out_ready = 0.
- Rounding, applied to the 2W-bit product p. Intermediate sums use 2W+1 bits so they cannot overflow. Let H = 2^(FRAC-1).
  - Mode 0: r = p >>> FRAC.
  - Mode 1: r = (p + (p<0 ? H-1 : H)) >>> FRAC.
  - Mode 2: r = (p + H-1 + bit FRAC of p) >>> FRAC. Exact ties go to the even result.
- Range stage:
  - ovf = 1 iff r lies outside [-2^(W-1), 2^(W-1)-1].
  - SAT = 1: clamp to the nearest bound.
  - SAT = 0: out_y = r[W-1:0].
  - ovf is reported in both cases.
- Sticky flag:
  - Set on a transfer with out_ovf = 1.
  - clr_ovf = 1 clears it on the next edge.
  - If a set and a clear land in the same cycle, the set wins.
- Reset mid-operation discards in-flight results. No output transfer may occur on the reset edge.

Decomposition:
- Shared package fxp_pkg holds:
  - Constants RND_TRUNC = 0, RND_HAFZ = 1, RND_EVEN = 2.
  - Localparams for the Q16 defaults (W = 32, FRAC = 16).
- One combinational sub-module, fxp_round_sat (parameters W, FRAC, RND_MODE, SAT):
  - Input: the 2W-bit product.
  - Outputs: the W-bit result and ovf.
  - Reused later by the Horner accumulator's rescale step.

Test Plan:
- Basic (W=32, FRAC=16, mode 1, SAT=1): a=0x00018000 (1.5), b=0x00020000 (2.0), tag=5, out_ready=1 -> out_valid exactly 2 clocks after accept; out_y=0x00030000, out_tag=5, out_ovf=0.
- Rounding tie, positive: a=1, b=0x8000 (p = +0.5 LSB) -> mode 0: 0, mode 1: 1, mode 2: 0. With a=3 (p = 1.5 LSB) -> mode 2: 2.
- Rounding tie, negative: a=-1, b=0x8000 (p = -0.5 LSB) -> mode 0: -1 (0xFFFFFFFF), mode 1: -1, mode 2: 0.
- Overflow, SAT=1: 0x7FFFFFFF*0x7FFFFFFF -> 0x7FFFFFFF; 0x80000000*0x80000000 -> 0x7FFFFFFF; 0x80000000*0x7FFFFFFF -> 0x80000000. Each has out_ovf=1, and ovf_sticky=1 after the first transfer. clr_ovf pulse -> 0. SAT=0 -> low W bits of r, with out_ovf still 1.
- Backpressure: out_ready=0, present 3 back-to-back inputs (tags 1,2,3) -> in_ready drops after 2 accepts and out_y/out_tag hold stable. Release out_ready -> tags emerge 1,2,3 with no loss or duplication, 1 per clock. Random ready/valid run of 1000 items is checked against a reference model.
- Reset mid-stream: assert rst with v1=v2=1 -> next cycle out_valid=0 and ovf_sticky=0; the next accepted input completes normally with latency 2.
